// File: rtl/mos_sched.sv
// mos_sched: shares one MOS matrix unit between two job requesters.
// A round-robin arbiter grants the unit, the owner's operand stream is
// forwarded to the MOS (one cycle after each accept), and MOS results are
// returned tagged with the owner index. A watchdog aborts a job whose MOS
// results stop arriving.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   req[1:0]              per-requester job request
//   grant[1:0]            one-hot current owner, 00 when idle
//   sX_size/valid/data    requester X job size (0=2x2, 1=4x4) and operand stream
//   sX_ready              requester X operand accept
//   mos_in_*              operand stream and matrix size towards the MOS
//   mos_out_*             result stream from the MOS
//   res_*                 result stream to requesters (data, id, last, error)
module mos_sched (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         req,
  output logic [1:0]         grant,
  input  logic               s0_size,
  input  logic               s1_size,
  input  logic               s0_valid,
  input  logic               s1_valid,
  input  logic signed [15:0] s0_data,
  input  logic signed [15:0] s1_data,
  output logic               s0_ready,
  output logic               s1_ready,
  output logic               mos_in_valid,
  output logic               mos_matrix_size,
  output logic signed [15:0] mos_in_data,
  input  logic               mos_out_valid,
  input  logic signed [39:0] mos_out_data,
  output logic               res_valid,
  output logic signed [39:0] res_data,
  output logic               res_id,
  output logic               res_last,
  output logic               res_err
);

  localparam int unsigned IN_W   = 16;
  localparam int unsigned OUT_W  = 40;
  localparam int unsigned ICNT_W = 6;
  localparam int unsigned OCNT_W = 5;
  localparam int unsigned WD_W   = 10;
  // Last watchdog value before expiry; expiry lands 1023 cycles after entry.
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(1022);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic [1:0]              grant_q, grant_d;
  logic                    own_q, own_d;
  logic                    last_q, last_d;
  logic                    size_q, size_d;
  logic [ICNT_W-1:0]       in_cnt_q, in_cnt_d;
  logic [OCNT_W-1:0]       out_cnt_q, out_cnt_d;
  logic [WD_W-1:0]         wd_q, wd_d;
  logic                    s0_ready_q, s0_ready_d;
  logic                    s1_ready_q, s1_ready_d;
  logic                    mos_in_valid_q, mos_in_valid_d;
  logic signed [IN_W-1:0]  mos_in_data_q, mos_in_data_d;
  logic                    res_valid_q, res_valid_d;
  logic signed [OUT_W-1:0] res_data_q, res_data_d;
  logic                    res_id_q, res_id_d;
  logic                    res_last_q, res_last_d;
  logic                    res_err_q, res_err_d;

  logic                    pick_c;
  logic                    hs_c;
  logic signed [IN_W-1:0]  hs_data_c;
  logic [ICNT_W-1:0]       in_total_c;
  logic [OCNT_W-1:0]       out_total_c;

  // Winner: a lone requester wins; with both, the one not served last.
  assign pick_c      = (req == 2'b11) ? ~last_q : req[1];
  assign hs_c        = own_q ? (s1_valid & s1_ready_q) : (s0_valid & s0_ready_q);
  assign hs_data_c   = own_q ? s1_data : s0_data;
  assign in_total_c  = size_q ? ICNT_W'(32) : ICNT_W'(8);
  assign out_total_c = size_q ? OCNT_W'(16) : OCNT_W'(4);

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      grant_q        <= 2'b00;
      own_q          <= 1'b0;
      last_q         <= 1'b1;
      size_q         <= 1'b0;
      in_cnt_q       <= '0;
      out_cnt_q      <= '0;
      wd_q           <= '0;
      s0_ready_q     <= 1'b0;
      s1_ready_q     <= 1'b0;
      mos_in_valid_q <= 1'b0;
      mos_in_data_q  <= '0;
      res_valid_q    <= 1'b0;
      res_data_q     <= '0;
      res_id_q       <= 1'b0;
      res_last_q     <= 1'b0;
      res_err_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      grant_q        <= grant_d;
      own_q          <= own_d;
      last_q         <= last_d;
      size_q         <= size_d;
      in_cnt_q       <= in_cnt_d;
      out_cnt_q      <= out_cnt_d;
      wd_q           <= wd_d;
      s0_ready_q     <= s0_ready_d;
      s1_ready_q     <= s1_ready_d;
      mos_in_valid_q <= mos_in_valid_d;
      mos_in_data_q  <= mos_in_data_d;
      res_valid_q    <= res_valid_d;
      res_data_q     <= res_data_d;
      res_id_q       <= res_id_d;
      res_last_q     <= res_last_d;
      res_err_q      <= res_err_d;
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d        = state_q;
    grant_d        = grant_q;
    own_d          = own_q;
    last_d         = last_q;
    size_d         = size_q;
    in_cnt_d       = in_cnt_q;
    out_cnt_d      = out_cnt_q;
    wd_d           = wd_q;
    mos_in_valid_d = 1'b0;
    mos_in_data_d  = '0;
    res_valid_d    = 1'b0;
    res_data_d     = '0;
    res_id_d       = 1'b0;
    res_last_d     = 1'b0;
    res_err_d      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        in_cnt_d  = '0;
        out_cnt_d = '0;
        wd_d      = '0;
        size_d    = 1'b0;
        grant_d   = 2'b00;
        if (req != 2'b00) begin
          own_d   = pick_c;
          grant_d = pick_c ? 2'b10 : 2'b01;
          size_d  = pick_c ? s1_size : s0_size;
          state_d = ST_LOAD;
        end
      end

      ST_LOAD: begin
        if (hs_c) begin
          mos_in_valid_d = 1'b1;
          mos_in_data_d  = hs_data_c;
          in_cnt_d       = in_cnt_q + ICNT_W'(1);
          if (in_cnt_q == in_total_c - ICNT_W'(1)) begin
            state_d = ST_WAIT;
          end
        end
      end

      ST_WAIT, ST_DRAIN: begin
        if (mos_out_valid) begin
          res_valid_d = 1'b1;
          res_data_d  = mos_out_data;
          res_id_d    = own_q;
          wd_d        = '0;
          out_cnt_d   = out_cnt_q + OCNT_W'(1);
          if (out_cnt_q == out_total_c - OCNT_W'(1)) begin
            res_last_d = 1'b1;
            state_d    = ST_IDLE;
            grant_d    = 2'b00;
            size_d     = 1'b0;
            last_d     = own_q;
          end else begin
            state_d = ST_DRAIN;
          end
        end else if (wd_q == WD_LAST) begin
          // MOS went silent: abort and hand the unit on.
          res_err_d = 1'b1;
          res_id_d  = own_q;
          state_d   = ST_IDLE;
          grant_d   = 2'b00;
          size_d    = 1'b0;
          last_d    = own_q;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Ready is registered, so it is derived from where the FSM is heading.
  always_comb begin
    s0_ready_d = (state_d == ST_LOAD) & grant_d[0];
    s1_ready_d = (state_d == ST_LOAD) & grant_d[1];
  end

  assign grant           = grant_q;
  assign s0_ready        = s0_ready_q;
  assign s1_ready        = s1_ready_q;
  assign mos_in_valid    = mos_in_valid_q;
  assign mos_in_data     = mos_in_data_q;
  assign mos_matrix_size = size_q;
  assign res_valid       = res_valid_q;
  assign res_data        = res_data_q;
  assign res_id          = res_id_q;
  assign res_last        = res_last_q;
  assign res_err         = res_err_q;

endmodule

// File: tb/tb_mos_sched.sv
// Directed bench for mos_sched: arbitration, load/drain, watchdog, reset.
module tb_mos_sched;

  logic               clk = 1'b0;
  logic               rst;
  logic [1:0]         req;
  logic [1:0]         grant;
  logic               s0_size, s1_size, s0_valid, s1_valid;
  logic signed [15:0] s0_data, s1_data;
  logic               s0_ready, s1_ready;
  logic               mos_in_valid, mos_matrix_size;
  logic signed [15:0] mos_in_data;
  logic               mos_out_valid;
  logic signed [39:0] mos_out_data;
  logic               res_valid, res_id, res_last, res_err;
  logic signed [39:0] res_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mos_sched dut (
    .clk(clk), .rst(rst), .req(req), .grant(grant),
    .s0_size(s0_size), .s1_size(s1_size),
    .s0_valid(s0_valid), .s1_valid(s1_valid),
    .s0_data(s0_data), .s1_data(s1_data),
    .s0_ready(s0_ready), .s1_ready(s1_ready),
    .mos_in_valid(mos_in_valid), .mos_matrix_size(mos_matrix_size),
    .mos_in_data(mos_in_data),
    .mos_out_valid(mos_out_valid), .mos_out_data(mos_out_data),
    .res_valid(res_valid), .res_data(res_data), .res_id(res_id),
    .res_last(res_last), .res_err(res_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1; req = 2'b00;
    s0_valid = 1'b0; s1_valid = 1'b0; s0_data = '0; s1_data = '0;
    s0_size = 1'b0; s1_size = 1'b0;
    mos_out_valid = 1'b0; mos_out_data = '0;
    tick();
    rst = 1'b0;
  endtask

  // Streams n operands from requester 'who'; reports forwarded count and
  // any cycle where timing, data, size or the other ready was off.
  task automatic do_load(input int who, input int n, input bit gaps, input bit exp_size,
                         output int nvalid, output int nbad);
    int acc;
    int cyc;
    bit hs;
    bit v;
    logic signed [15:0] dw;
    logic signed [15:0] q[$];
    acc = 0; cyc = 0; nvalid = 0; nbad = 0;
    while (acc < n && cyc < 300) begin
      v  = gaps ? (cyc % 2 == 0) : 1'b1;
      dw = 16'(acc + 1);
      if (who == 1) dw = -dw;
      if (who == 1) begin
        s1_valid = v; s1_data = dw; s0_valid = 1'b1; s0_data = 16'sd99;
        hs = v && s1_ready;
        if (s0_ready !== 1'b0) nbad++;
      end else begin
        s0_valid = v; s0_data = dw; s1_valid = 1'b1; s1_data = 16'sd77;
        hs = v && s0_ready;
        if (s1_ready !== 1'b0) nbad++;
      end
      if (hs) begin q.push_back(dw); acc++; end
      tick();
      cyc++;
      if (mos_in_valid !== hs) nbad++;
      if (mos_in_valid === 1'b1) begin
        nvalid++;
        if (q.size() == 0 || mos_in_data !== q.pop_front()) nbad++;
        if (mos_matrix_size !== exp_size) nbad++;
      end else if (mos_in_data !== 16'sd0) nbad++;
    end
    s0_valid = 1'b0; s1_valid = 1'b0;
  endtask

  // Feeds n MOS results (with one idle cycle between) and checks the echo.
  task automatic do_drain(input int who, input int n, input bit extreme, output int nbad);
    logic signed [39:0] v;
    nbad = 0;
    for (int i = 0; i < n; i++) begin
      if (extreme) v = (i % 2 == 0) ? {1'b1, 39'd0} : {1'b0, {39{1'b1}}};
      else begin
        v = 40'(i + 1) * 40'sd1234567;
        if (i % 2 == 1) v = -v;
      end
      mos_out_valid = 1'b1; mos_out_data = v;
      tick();
      mos_out_valid = 1'b0; mos_out_data = '0;
      if (res_valid !== 1'b1 || res_data !== v || res_id !== who[0] || res_err !== 1'b0) nbad++;
      if (res_last !== (i == n - 1)) nbad++;
      if (i != n - 1) begin
        tick();
        if (res_valid !== 1'b0) nbad++;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 2'b11; s0_valid = 1'b1; s1_valid = 1'b1;
    s0_data = 16'sd5; s1_data = 16'sd6; s0_size = 1'b1; s1_size = 1'b1;
    mos_out_valid = 1'b1; mos_out_data = 40'sd123;
    tick();
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL reset_grant got %b exp 00", grant); end
    checks++; if ({s0_ready, s1_ready, mos_in_valid, mos_matrix_size} !== 4'b0) begin
      errors++; $display("FAIL reset_ctl got %b exp 0000", {s0_ready, s1_ready, mos_in_valid, mos_matrix_size}); end
    checks++; if (mos_in_data !== 16'sd0) begin errors++; $display("FAIL reset_in_data got %0d exp 0", mos_in_data); end
    checks++; if ({res_valid, res_id, res_last, res_err} !== 4'b0) begin
      errors++; $display("FAIL reset_res got %b exp 0000", {res_valid, res_id, res_last, res_err}); end
    checks++; if (res_data !== 40'sd0) begin errors++; $display("FAIL reset_res_data got %0d exp 0", res_data); end
    apply_reset();
    mos_out_valid = 1'b1; mos_out_data = 40'sd55;
    tick();
    mos_out_valid = 1'b0;
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL idle_ignore got %b exp 0", res_valid); end
  endtask

  task automatic test_2x2();
    int nv, nb;
    apply_reset();
    req = 2'b01; s0_size = 1'b0;
    tick();
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL b2_grant got %b exp 01", grant); end
    req = 2'b00;  // dropping req must not abort the job
    do_load(0, 8, 1'b0, 1'b0, nv, nb);
    checks++; if (nv !== 8) begin errors++; $display("FAIL b2_in_count got %0d exp 8", nv); end
    checks++; if (nb !== 0) begin errors++; $display("FAIL b2_load_bad got %0d exp 0", nb); end
    checks++; if (s0_ready !== 1'b0) begin errors++; $display("FAIL b2_ready_after got %b exp 0", s0_ready); end
    do_drain(0, 4, 1'b0, nb);
    checks++; if (nb !== 0) begin errors++; $display("FAIL b2_drain_bad got %0d exp 0", nb); end
    checks++; if (grant !== 2'b00 || mos_matrix_size !== 1'b0) begin
      errors++; $display("FAIL b2_grant_end got %b/%b exp 00/0", grant, mos_matrix_size); end
  endtask

  task automatic test_back_to_back();
    int nv, nb;
    apply_reset();
    req = 2'b11;
    tick();
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL rr_first got %b exp 01", grant); end
    do_load(0, 8, 1'b0, 1'b0, nv, nb);
    do_drain(0, 4, 1'b0, nb);
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL rr_idle got %b exp 00", grant); end
    tick();
    checks++; if (grant !== 2'b10) begin errors++; $display("FAIL rr_second got %b exp 10", grant); end
    do_load(1, 8, 1'b0, 1'b0, nv, nb);
    checks++; if (nv !== 8 || nb !== 0) begin errors++; $display("FAIL rr_load1 got %0d/%0d exp 8/0", nv, nb); end
    do_drain(1, 4, 1'b0, nb);
    checks++; if (nb !== 0) begin errors++; $display("FAIL rr_drain1 got %0d exp 0", nb); end
    tick();
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL rr_third got %b exp 01", grant); end
  endtask

  task automatic test_4x4_gaps();
    int nv, nb;
    apply_reset();
    req = 2'b10; s1_size = 1'b1; s0_size = 1'b0;
    tick();
    checks++; if (grant !== 2'b10 || mos_matrix_size !== 1'b1) begin
      errors++; $display("FAIL g4_grant got %b/%b exp 10/1", grant, mos_matrix_size); end
    do_load(1, 32, 1'b1, 1'b1, nv, nb);
    checks++; if (nv !== 32) begin errors++; $display("FAIL g4_in_count got %0d exp 32", nv); end
    checks++; if (nb !== 0) begin errors++; $display("FAIL g4_load_bad got %0d exp 0", nb); end
    checks++; if (mos_matrix_size !== 1'b1) begin errors++; $display("FAIL g4_size_wait got %b exp 1", mos_matrix_size); end
    do_drain(1, 16, 1'b0, nb);
    checks++; if (nb !== 0) begin errors++; $display("FAIL g4_drain_bad got %0d exp 0", nb); end
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL g4_grant_end got %b exp 00", grant); end
  endtask

  task automatic test_timeout();
    int nv, nb, k, nres;
    apply_reset();
    req = 2'b01; s0_size = 1'b0;
    tick();
    do_load(0, 8, 1'b0, 1'b0, nv, nb);
    k = 0; nres = 0;
    while (k < 1100) begin
      tick();
      k++;
      if (res_valid === 1'b1) nres++;
      if (res_err === 1'b1) break;
    end
    checks++; if (k !== 1023) begin errors++; $display("FAIL to_latency got %0d exp 1023", k); end
    checks++; if (nres !== 0) begin errors++; $display("FAIL to_no_res got %0d exp 0", nres); end
    checks++; if (grant !== 2'b00 || res_id !== 1'b0) begin
      errors++; $display("FAIL to_grant_id got %b/%b exp 00/0", grant, res_id); end
    req = 2'b11;
    tick();
    checks++; if (res_err !== 1'b0) begin errors++; $display("FAIL to_pulse got %b exp 0", res_err); end
    checks++; if (grant !== 2'b10) begin errors++; $display("FAIL to_rr got %b exp 10", grant); end
  endtask

  task automatic test_reset_mid_load();
    int nv, nb;
    apply_reset();
    req = 2'b01; s0_size = 1'b0;
    tick();
    mos_out_valid = 1'b1; mos_out_data = 40'sd9;
    tick();
    mos_out_valid = 1'b0;
    checks++; if (res_valid !== 1'b0 || mos_in_valid !== 1'b0) begin
      errors++; $display("FAIL ml_load_ignore got %b/%b exp 0/0", res_valid, mos_in_valid); end
    do_load(0, 5, 1'b0, 1'b0, nv, nb);
    checks++; if (nv !== 5 || s0_ready !== 1'b1) begin
      errors++; $display("FAIL ml_partial got %0d/%b exp 5/1", nv, s0_ready); end
    rst = 1'b1; s0_valid = 1'b1; s0_data = 16'sd42;
    tick();
    rst = 1'b0; s0_valid = 1'b0; req = 2'b00;
    checks++; if ({grant, s0_ready, s1_ready, mos_in_valid, mos_matrix_size, res_valid, res_last, res_err} !== 9'b0
                  || mos_in_data !== 16'sd0) begin
      errors++; $display("FAIL ml_reset_out got %b exp 0",
                         {grant, s0_ready, s1_ready, mos_in_valid, mos_matrix_size, res_valid, res_last, res_err}); end
    mos_out_valid = 1'b1; mos_out_data = 40'sd3;
    tick();
    mos_out_valid = 1'b0;
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL ml_stale_mos got %b exp 0", res_valid); end
    req = 2'b11;
    tick();
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL ml_fresh_grant got %b exp 01", grant); end
    req = 2'b01;
    do_load(0, 8, 1'b0, 1'b0, nv, nb);
    checks++; if (nv !== 8 || nb !== 0) begin errors++; $display("FAIL ml_fresh_load got %0d/%0d exp 8/0", nv, nb); end
    do_drain(0, 4, 1'b0, nb);
    checks++; if (nb !== 0) begin errors++; $display("FAIL ml_fresh_drain got %0d exp 0", nb); end
  endtask

  task automatic test_extremes();
    int nv, nb;
    apply_reset();
    req = 2'b10; s1_size = 1'b0;
    tick();
    do_load(1, 8, 1'b0, 1'b0, nv, nb);
    do_drain(1, 4, 1'b1, nb);
    checks++; if (nb !== 0) begin errors++; $display("FAIL ext_data got %0d bad exp 0", nb); end
  endtask

  initial begin
    rst = 1'b1; req = 2'b00;
    s0_size = 1'b0; s1_size = 1'b0; s0_valid = 1'b0; s1_valid = 1'b0;
    s0_data = '0; s1_data = '0; mos_out_valid = 1'b0; mos_out_data = '0;
    test_reset();
    test_2x2();
    test_back_to_back();
    test_4x4_gaps();
    test_timeout();
    test_reset_mid_load();
    test_extremes();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mos_sched.md
MOS_SCHED -- requirements
Module: mos_sched

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all logic on rising edge.
REQ-002 SHALL have ports: rst  in  1  synchronous, active-high reset, sampled on rising clk.
REQ-003 SHALL have ports: req  in  2  per-requester job request, held high until res_last for that requester.
REQ-004 SHALL have ports: grant  out  2  one-hot owner of the MOS unit; 00 when idle.
REQ-005 SHALL have ports: s0_size, s1_size  in  1 each  job matrix size; 0 = 2x2, 1 = 4x4.
REQ-006 SHALL have ports: s0_valid, s1_valid  in  1 each, and s0_data, s1_data  in  signed 16 each  operand stream.
REQ-007 SHALL have ports: s0_ready, s1_ready  out  1 each  operand accept.
REQ-008 SHALL have ports: mos_in_valid  out  1, mos_matrix_size  out  1, mos_in_data  out  signed 16  (to MOS).
REQ-009 SHALL have ports: mos_out_valid  in  1, mos_out_data  in  signed 40  (from MOS).
REQ-010 SHALL have ports: res_valid  out  1, res_data  out  signed 40, res_id  out  1, res_last  out  1, res_err  out  1.

Function
REQ-011 SHALL implement a four-state FSM: IDLE, LOAD, WAIT, DRAIN.
REQ-012 SHALL define per job N = 2 (size 0) or 4 (size 1), input count 2*N*N (8 or 32), output count N*N (4 or 16).
REQ-013 IDLE: if req != 00, SHALL pick the winner round-robin, set grant, latch the winner's size, and enter LOAD next cycle.
  - Only one requester high: it wins.
  - Both high: the requester not served last wins; requester 0 first after reset.
REQ-014 LOAD: sX_ready SHALL be high only for the granted X while accepted count < input count; ready SHALL be low for the other requester.
REQ-015 Each sX_valid & sX_ready handshake SHALL produce, on the next cycle:
  - mos_in_valid = 1;
  - mos_in_data = the accepted word;
  - mos_matrix_size = the latched size.
  Without a handshake, mos_in_valid SHALL be 0 and mos_in_data 0.
REQ-016 mos_matrix_size SHALL hold the latched size for the whole job and SHALL be 0 in IDLE.
REQ-017 On the last input handshake, FSM SHALL go to WAIT; input gaps (valid low) SHALL stall without error.
REQ-018 WAIT: first mos_out_valid SHALL enter DRAIN and count as result 1.
REQ-019 In WAIT and DRAIN, each mos_out_valid SHALL produce, next cycle:
  - res_valid = 1;
  - res_data = mos_out_data, unmodified 40-bit signed;
  - res_id = granted index.
REQ-020 res_last SHALL be high with the result that reaches the output count; FSM SHALL then return to IDLE and clear grant the same cycle.
REQ-021 mos_out_valid in IDLE or LOAD SHALL be ignored; no res_valid.
REQ-022 Watchdog: a 10-bit counter SHALL run in WAIT/DRAIN, clear on each mos_out_valid, and expire at 1023 cycles without one. On expiry:
  - res_err SHALL pulse 1 cycle with res_id;
  - FSM SHALL go to IDLE and clear grant;
  - the round-robin pointer SHALL update as on normal completion.
REQ-023 req deasserting mid-job SHALL NOT abort the job.
REQ-024 Counters SHALL be 6-bit input and 5-bit output, with no wrap-around within a job.

Reset
REQ-025 On rst = 1 at a rising edge, outputs SHALL be:
  - grant = 00;
  - s0_ready, s1_ready, mos_in_valid, mos_matrix_size = 0;
  - mos_in_data = 0;
  - res_valid, res_data, res_id, res_last, res_err = 0.
REQ-026 Reset SHALL put the FSM in IDLE, clear all counters and the watchdog, and set round-robin priority to requester 0.
REQ-027 rst asserted mid-job SHALL abandon the job with no res_last or res_err; MOS outputs arriving afterwards SHALL be ignored.

Verification
REQ-028 2x2 job: req=01, s0_size=0, 8 words 1..8 back-to-back -> mos_in_valid for 8 consecutive cycles, each one cycle after its handshake, mos_matrix_size=0; 4 mos_out_valid -> 4 res_valid with res_id=0, res_last on the 4th, grant=00 after.
REQ-029 Contention: req=11 out of reset -> grant=01 first; after its res_last -> grant=10; then req=11 again -> grant=01.
REQ-030 4x4 job with s1_valid toggling every other cycle -> exactly 32 mos_in_valid, mos_matrix_size=1 throughout; 16 results with res_id=1.
REQ-031 Timeout: complete load, never drive mos_out_valid -> res_err pulses exactly 1023 cycles after entering WAIT; no res_valid; grant=00.
REQ-032 Reset mid-LOAD after 5 of 8 words -> all outputs 0 next cycle; a fresh job then completes normally with 8 inputs.
REQ-033 Signed extremes: mos_out_data = -2^39 and 2^39-1 -> res_data bit-exact.
